// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with sync reset, zero register, write bypass and busy scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              err_wr
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy, busy_n;
  logic              wr_ok, rsv_ok, zero_a, zero_b;
  logic [DATA_W-1:0] rd_a, rd_b;
  assign wr_ok  = we && !(ZERO_REG != 0 && rw == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  assign zero_a = ZERO_REG != 0 && ra == '0;
  assign zero_b = ZERO_REG != 0 && rb == '0;
  assign rd_a   = zero_a ? '0 : (BYPASS != 0 && wr_ok && rw == ra) ? din : mem[ra];
  assign rd_b   = zero_b ? '0 : (BYPASS != 0 && wr_ok && rw == rb) ? din : mem[rb];
  // A reservation in the same cycle as the write wins, so set after clear.
  always_comb begin
    busy_n = busy;
    if (wr_ok) busy_n[rw] = 1'b0;
    if (rsv_ok) busy_n[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy   <= '0;
      douta  <= '0;
      doutb  <= '0;
      busy_a <= 1'b0;
      busy_b <= 1'b0;
      err_wr <= 1'b0;
    end else begin
      if (wr_ok) mem[rw] <= din;
      busy   <= busy_n;
      err_wr <= wr_ok && !busy[rw];
      if (re) begin
        douta  <= rd_a;
        doutb  <= rd_b;
        busy_a <= busy_n[ra];
        busy_b <= busy_n[rb];
      end
    end
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the 64-bit, 32-entry datapath register file.
- Has two synchronous read ports and one write port, with width and depth set by parameters.
- Adds synchronous reset, a hardwired zero register, same-cycle read/write with write-to-read bypass, and a per-register busy scoreboard for multi-cycle result writeback.
- Sits between the decode stage and the adder/Mux1 operand path; Mux2 output drives din.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write to a read address forwards din to the read output.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- we  in  1  write enable.
- rw  in  ADDR_W  write address.
- din  in  DATA_W  write data.
- re  in  1  read enable; both read ports update only when high.
- ra  in  ADDR_W  read address port A.
- rb  in  ADDR_W  read address port B.
- douta  out  DATA_W  registered read data port A.
- doutb  out  DATA_W  registered read data port B.
- rsv_en  in  1  reserve (mark busy) register rsv_addr.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_a  out  1  registered busy bit for ra, sampled with douta.
- busy_b  out  1  registered busy bit for rb, sampled with doutb.
- err_wr  out  1  one-cycle pulse: the previous cycle wrote a non-busy register.

Behaviour:
- Reset (rst=1 at the clock edge):
  - All registers go to 0.
  - All busy bits go to 0.
  - douta, doutb, busy_a, busy_b and err_wr go to 0.
  - rst has priority over we, re and rsv_en in that cycle.
  - Asserting rst mid-sequence discards all reservations and pending writes.
- Write: when we=1, reg[rw] <= din at the edge.
  - With ZERO_REG=1 and rw=0, the write is dropped and err_wr is not raised.
- Read:
  - Latency is 1 cycle. With re=1 at edge N, douta/doutb are valid after edge N.
  - With re=0, douta, doutb, busy_a and busy_b hold their values.
  - Read and write in the same cycle are legal. The old block blocked reads while we=1; this block does not.
- Bypass:
  - BYPASS=1, re=1, we=1 and rw==ra (rw!=0 when ZERO_REG=1): douta <= din. The same rule applies to port B.
  - BYPASS=0: the read returns the pre-write value.
- Zero register: with ZERO_REG=1, ra=0 gives douta=0 regardless of writes or bypass. The same applies to port B.
- Scoreboard:
  - rsv_en=1 sets busy[rsv_addr].
  - we=1 clears busy[rw].
  - If rsv_en and we hit the same address in the same cycle, the busy bit ends set (the new reservation wins).
  - With ZERO_REG=1, rsv_addr=0 is ignored.
- busy_a/busy_b (when re=1) report the busy bit value after the same edge's update:
  - A same-cycle write to ra reports 0.
  - A same-cycle reserve of ra reports 1.
  - A same-cycle write and reserve of ra reports 1.
- err_wr:
  - Registered. It is 1 after an edge where we=1, rw is a writable register, and busy[rw] was 0 before that edge.
  - The write still completes.
  - err_wr returns to 0 on the next edge unless the condition recurs.
- Arithmetic: none. Data is stored and returned bit-exact, and no sign handling is done.

Test Plan:
1. Reset: write reg5=45, then pulse rst.
   - Expect douta=doutb=busy_a=err_wr=0.
   - Read ra=5 -> douta=0.
2. Simultaneous read/write with bypass: we=1, rw=7, din=0x11, re=1, ra=7, rb=7 in one cycle.
   - Next cycle douta=doutb=0x11.
   - With BYPASS=0 the same stimulus gives the old value 0.
3. Zero register: we=1, rw=0, din=0xFFFF, then ra=0 -> douta=0 and err_wr=0.
   - rsv_en with rsv_addr=0, then read -> busy_a=0.
4. Scoreboard:
   - rsv_en, rsv_addr=3; then read ra=3 -> busy_a=1.
   - Write rw=3, din=11 -> busy clears, err_wr=0.
   - Re-read -> douta=11, busy_a=0.
5. Unreserved write and collision:
   - we to rw=9 with no reservation -> err_wr=1 for exactly one cycle.
   - Same-cycle rsv_en and we on address 4 -> busy[4]=1.
6. Read hold and mid-operation reset:
   - re=0 while ra changes -> douta/doutb unchanged.
   - rst asserted while busy[3]=1 -> busy_a=0 on re-read.
